hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It is the successor to the single-cycle hazard unit and adds three things: decode-stage forwarding from both M and W, a multi-cycle divider stall sequencer with per-stage stall/flush control, and precise exception flush. It also keeps a saturating stall-cycle performance counter. It sits beside the datapath and drives every pipeline-register enable and clear.

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decode/execute forwarding, load-use and branch stalls,
// multi-cycle divider stall sequencer, precise exception flush and a stall-cycle counter.
module hazard_ctrl #(
   parameter int REG_W      = 5,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic             branchD,
   input  logic             jumpregD,
   input  logic [REG_W-1:0] rsE,
   input  logic [REG_W-1:0] rtE,
   input  logic [REG_W-1:0] writeregE,
   input  logic             regwriteE,
   input  logic             memtoregE,
   input  logic             divstartE,
   input  logic [REG_W-1:0] writeregM,
   input  logic             regwriteM,
   input  logic             memtoregM,
   input  logic             excM,
   input  logic [REG_W-1:0] writeregW,
   input  logic             regwriteW,
   output logic [1:0]       forwardaD,
   output logic [1:0]       forwardbD,
   output logic [1:0]       forwardaE,
   output logic [1:0]       forwardbE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             div_busy,
   output logic             div_done,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DW = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_nx;
   logic [DW-1:0] cnt, cnt_nx;
   logic          lwstall, brstall, divstall;
   logic          e_hit, m_hit;

   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, wm, ww,
                                          input logic rwm, rww);
      if (src == '0)              return 2'b00;
      if (rwm && src == wm)       return 2'b10;
      if (rww && src == ww)       return 2'b01;
      return 2'b00;
   endfunction

   assign forwardaD = fwd_sel(rsD, writeregM, writeregW, regwriteM, regwriteW);
   assign forwardbD = fwd_sel(rtD, writeregM, writeregW, regwriteM, regwriteW);
   assign forwardaE = fwd_sel(rsE, writeregM, writeregW, regwriteM, regwriteW);
   assign forwardbE = fwd_sel(rtE, writeregM, writeregW, regwriteM, regwriteW);

   assign lwstall  = memtoregE && (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
   assign e_hit    = regwriteE && (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
   assign m_hit    = memtoregM && (writeregM != '0) && (writeregM == rsD || writeregM == rtD);
   assign brstall  = (branchD || jumpregD) && (e_hit || m_hit);
   assign divstall = (state == IDLE && divstartE) || state == BUSY;

   // Exception and reset both squash the whole pipe and release every stall.
   always_comb begin
      stallE = divstall;
      stallD = divstall || lwstall || brstall;
      stallF = stallD;
      flushE = stallD && !stallE;
      flushM = stallE;
      flushD = 1'b0;
      flushW = 1'b0;
      if (rst || excM) begin
         stallF = 1'b0;
         stallD = 1'b0;
         stallE = 1'b0;
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: if (divstartE) begin
            state_nx = BUSY;
            cnt_nx   = DW'(DIV_CYCLES - 1);
         end
         BUSY: if (cnt == DW'(1)) begin
            state_nx = DONE;
            cnt_nx   = '0;
         end else begin
            cnt_nx   = cnt - DW'(1);
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (excM) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (stallF && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign div_busy = (state != IDLE);
   assign div_done = (state == DONE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for the combinational hazard logic,
// hand-written sequences for divide, exception and reset, checked through a scoreboard queue.
module tb_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int DIVC  = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic             branchD, jumpregD, regwriteE, memtoregE, divstartE;
   logic             regwriteM, memtoregM, excM, regwriteW;
   logic [1:0]       forwardaD, forwardbD, forwardaE, forwardbE;
   logic             stallF, stallD, stallE, flushD, flushE, flushM, flushW;
   logic             div_busy, div_done;
   logic [CNT_W-1:0] stall_cnt;

   hazard_ctrl #(.REG_W(REG_W), .DIV_CYCLES(DIVC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpregD(jumpregD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
      .memtoregE(memtoregE), .divstartE(divstartE), .writeregM(writeregM),
      .regwriteM(regwriteM), .memtoregM(memtoregM), .excM(excM), .writeregW(writeregW),
      .regwriteW(regwriteW), .forwardaD(forwardaD), .forwardbD(forwardbD),
      .forwardaE(forwardaE), .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD),
      .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // stl = {F,D,E}, flu = {D,E,M,W}, fwd = {aD,bD,aE,bE}
   typedef struct packed {
      logic [2:0] stl;
      logic [3:0] flu;
      logic [7:0] fwd;
      logic       busy;
      logic       done;
   } obs_t;

   // flags = {branchD, jumpregD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, excM}
   typedef struct {
      logic [4:0] rsD, rtD, rsE, rtE, weE, weM, weW;
      logic [7:0] flags;
      logic [7:0] fwd;
      logic [2:0] stl;
      logic [3:0] flu;
   } vec_t;

   obs_t  sbq[$];
   string nmq[$];
   int    checks   = 0;
   int    failures = 0;

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         obs_t  e, g;
         string n;
         e = sbq.pop_front();
         n = nmq.pop_front();
         g = '{stl: {stallF, stallD, stallE}, flu: {flushD, flushE, flushM, flushW},
               fwd: {forwardaD, forwardbD, forwardaE, forwardbE},
               busy: div_busy, done: div_done};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, g, e);
         end
      end
   end

   task automatic clear_in();
      {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
      {branchD, jumpregD, regwriteE, memtoregE, divstartE} = '0;
      {regwriteM, memtoregM, excM, regwriteW} = '0;
   endtask

   task automatic step(input string nm, input obs_t e);
      sbq.push_back(e);
      nmq.push_back(nm);
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t mk(input logic [2:0] s, input logic [3:0] f,
                               input logic b, input logic d);
      obs_t o;
      o = '{stl: s, flu: f, fwd: 8'h00, busy: b, done: d};
      return o;
   endfunction

   task automatic check_cnt(input string nm, input logic [CNT_W-1:0] exp);
      checks++;
      if (stall_cnt !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, stall_cnt, exp);
      end
   endtask

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{0,0,3,3,0,3,3, 8'b0000_1010, 8'b00_00_10_10, 3'b000, 4'b0000};
      tbl[1]  = '{0,0,3,3,0,3,3, 8'b0000_0010, 8'b00_00_01_01, 3'b000, 4'b0000};
      tbl[2]  = '{0,0,0,3,0,3,3, 8'b0000_0010, 8'b00_00_00_01, 3'b000, 4'b0000};
      tbl[3]  = '{0,5,0,0,5,0,0, 8'b0011_0000, 8'b00_00_00_00, 3'b110, 4'b0100};
      tbl[4]  = '{7,0,0,0,0,7,0, 8'b1000_1100, 8'b10_00_00_00, 3'b110, 4'b0100};
      tbl[5]  = '{7,0,0,0,0,0,7, 8'b1000_0010, 8'b01_00_00_00, 3'b000, 4'b0000};
      tbl[6]  = '{9,0,0,0,9,0,0, 8'b0110_0000, 8'b00_00_00_00, 3'b110, 4'b0100};
      tbl[7]  = '{0,0,0,0,0,0,0, 8'b1011_0000, 8'b00_00_00_00, 3'b000, 4'b0000};
      tbl[8]  = '{0,5,4,0,5,4,0, 8'b0011_1001, 8'b00_00_10_00, 3'b000, 4'b1111};
      tbl[9]  = '{0,6,0,0,0,0,6, 8'b0000_0000, 8'b00_00_00_00, 3'b000, 4'b0000};
      tbl[10] = '{2,4,0,0,0,4,2, 8'b0000_1010, 8'b01_10_00_00, 3'b000, 4'b0000};

      clear_in();
      rst = 1'b1;
      step("rst_c0", mk(3'b000, 4'b1111, 1'b0, 1'b0));
      step("rst_c1", mk(3'b000, 4'b1111, 1'b0, 1'b0));
      rst = 1'b0;
      step("post_rst", mk(3'b000, 4'b0000, 1'b0, 1'b0));
      check_cnt("cnt_post_rst", 3'd0);

      for (int i = 0; i < 11; i++) begin
         obs_t e;
         rsD = tbl[i].rsD; rtD = tbl[i].rtD; rsE = tbl[i].rsE; rtE = tbl[i].rtE;
         writeregE = tbl[i].weE; writeregM = tbl[i].weM; writeregW = tbl[i].weW;
         {branchD, jumpregD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, excM} =
            tbl[i].flags;
         e = '{stl: tbl[i].stl, flu: tbl[i].flu, fwd: tbl[i].fwd, busy: 1'b0, done: 1'b0};
         step($sformatf("vec%0d", i), e);
      end
      check_cnt("cnt_after_table", 3'd3);

      // divide with back-to-back restart, then exception in the second BUSY cycle
      clear_in();
      divstartE = 1'b1;
      step("div_t0", mk(3'b111, 4'b0010, 1'b0, 1'b0));
      step("div_t1", mk(3'b111, 4'b0010, 1'b1, 1'b0));
      step("div_t2", mk(3'b111, 4'b0010, 1'b1, 1'b0));
      step("div_t3", mk(3'b111, 4'b0010, 1'b1, 1'b0));
      step("div_done", mk(3'b000, 4'b0000, 1'b1, 1'b1));
      check_cnt("cnt_after_div", 3'd7);
      step("div2_idle", mk(3'b111, 4'b0010, 1'b0, 1'b0));
      divstartE = 1'b0;
      step("div2_busy1", mk(3'b111, 4'b0010, 1'b1, 1'b0));
      excM = 1'b1;
      step("div2_exc", mk(3'b000, 4'b1111, 1'b1, 1'b0));
      excM = 1'b0;
      step("exc_idle", mk(3'b000, 4'b0000, 1'b0, 1'b0));
      step("exc_nodone", mk(3'b000, 4'b0000, 1'b0, 1'b0));
      check_cnt("cnt_saturated", 3'd7);

      // reset in the middle of BUSY
      divstartE = 1'b1;
      step("div3_idle", mk(3'b111, 4'b0010, 1'b0, 1'b0));
      divstartE = 1'b0;
      step("div3_busy", mk(3'b111, 4'b0010, 1'b1, 1'b0));
      rst = 1'b1;
      step("div3_rst", mk(3'b000, 4'b1111, 1'b1, 1'b0));
      rst = 1'b0;
      step("rst_idle", mk(3'b000, 4'b0000, 1'b0, 1'b0));
      step("rst_nodone", mk(3'b000, 4'b0000, 1'b0, 1'b0));
      check_cnt("cnt_after_rst", 3'd0);

      if (sbq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
